// File: rtl/counter_pkg.sv
// Shared encodings and helpers for the sync_updown_counter_n family.
package counter_pkg;

    localparam logic DIR_UP    = 1'b0;
    localparam logic DIR_DOWN  = 1'b1;
    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

    // Widest counter the Gray helper can encode.
    localparam int unsigned GRAY_MAX_W = 32;

    function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/counter_next_logic.sv
// Next-state, boundary-flag and cascade terminal-count logic for the up/down counter.
module counter_next_logic
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned MAX_COUNT = (2**WIDTH) - 1
) (
    input  logic [WIDTH-1:0] q,
    input  logic             en,
    input  logic             M,
    input  logic             sat,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q_next,
    output logic             ovf_next,
    output logic             unf_next,
    output logic             tc
);

    localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MAX_COUNT);

    logic at_max;
    logic at_zero;

    assign at_max  = (q == MAX_Q);
    assign at_zero = (q == '0);

    // Load beats count beats hold; wrap point is MAX_COUNT, not the natural rollover.
    always_comb begin
        q_next   = q;
        ovf_next = 1'b0;
        unf_next = 1'b0;
        if (load) begin
            q_next = (d > MAX_Q) ? MAX_Q : d;
        end else if (en) begin
            if (M == DIR_UP) begin
                if (at_max) begin
                    ovf_next = 1'b1;
                    q_next   = (sat == MODE_SAT) ? q : '0;
                end else begin
                    q_next = q + WIDTH'(1);
                end
            end else begin
                if (at_zero) begin
                    unf_next = 1'b1;
                    q_next   = (sat == MODE_WRAP) ? MAX_Q : q;
                end else begin
                    q_next = q - WIDTH'(1);
                end
            end
        end
    end

    // Zero-latency so a following stage can use it as its enable in the same cycle.
    assign tc = en & (((M == DIR_UP) & at_max) | ((M == DIR_DOWN) & at_zero));

endmodule

// File: rtl/sync_updown_counter_n.sv
// Parametrised up/down counter with load, enable, wrap/saturate and cascade tc.
// Optional registered Gray output g when SYNC_UPDOWN_GRAY_OUT_EN is defined.
module sync_updown_counter_n
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned MAX_COUNT = (2**WIDTH) - 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    input  logic             M,
    input  logic             sat,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qb,
    output logic             tc,
    output logic             ovf,
    output logic             unf
`ifdef SYNC_UPDOWN_GRAY_OUT_EN
    ,
    output logic [WIDTH-1:0] g
`endif
);

    if (WIDTH < 2) begin : g_bad_width
        $error("sync_updown_counter_n: WIDTH must be at least 2");
    end
    if (64'(MAX_COUNT) >= (64'd1 << WIDTH)) begin : g_bad_max
        $error("sync_updown_counter_n: MAX_COUNT must be below 2**WIDTH");
    end

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic             ovf_q;
    logic             ovf_d;
    logic             unf_q;
    logic             unf_d;

    counter_next_logic #(
        .WIDTH     (WIDTH),
        .MAX_COUNT (MAX_COUNT)
    ) u_next (
        .q        (q_q),
        .en       (en),
        .M        (M),
        .sat      (sat),
        .load     (load),
        .d        (d),
        .q_next   (q_d),
        .ovf_next (ovf_d),
        .unf_next (unf_d),
        .tc       (tc)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            q_q   <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            q_q   <= q_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign q   = q_q;
    assign qb  = ~q_q;
    assign ovf = ovf_q;
    assign unf = unf_q;

`ifdef SYNC_UPDOWN_GRAY_OUT_EN
    // Single-bit-change wrap only holds for the full binary range.
    if (64'(MAX_COUNT) != ((64'd1 << WIDTH) - 64'd1)) begin : g_bad_gray_max
        $error("sync_updown_counter_n: Gray output requires MAX_COUNT == 2**WIDTH-1");
    end
    if (WIDTH > GRAY_MAX_W) begin : g_bad_gray_width
        $error("sync_updown_counter_n: Gray output limited to GRAY_MAX_W bits");
    end

    logic [WIDTH-1:0] g_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            g_q <= '0;
        end else begin
            g_q <= WIDTH'(bin2gray(GRAY_MAX_W'(q_d)));
        end
    end

    assign g = g_q;
`endif

endmodule

// File: doc/sync_updown_counter_n.md
Name: sync_updown_counter_n

Overview:
- Parametrised synchronous up/down counter; successor to the fixed 4-bit T-flip-flop up/down counter.
- Adds generic width and programmable modulus.
- Adds synchronous load, count enable and wrap/saturate mode.
- Adds cascade terminal-count and registered overflow/underflow flags.
- Used as building block for timers, dividers and cascaded multi-digit counters (e.g. BCD chains with MAX_COUNT=9).

Parameters:
- WIDTH, 4, counter width in bits (≥2).
- MAX_COUNT, 2**WIDTH-1, terminal value; counter range is 0..MAX_COUNT; must be < 2**WIDTH.

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset; low clears all state immediately
- en  input  1  count enable
- M  input  1  direction: 0 = up, 1 = down (same sense as existing counter)
- sat  input  1  mode: 0 = wrap at boundary, 1 = saturate/hold at boundary
- load  input  1  synchronous load strobe
- d  input  WIDTH  load value
- q  output  WIDTH  current count
- qb  output  WIDTH  bitwise complement of q
- tc  output  1  terminal count for cascading (combinational)
- ovf  output  1  registered one-cycle pulse: up-wrap or up-saturate hit
- unf  output  1  registered one-cycle pulse: down-wrap or down-saturate hit

Behaviour:
- Reset (reset=0, async): q=0, qb=all ones, ovf=0, unf=0. tc follows the combinational rule below.
- Priority at each rising clock edge with reset=1: load > en > hold.
- Load:
  - q <= d if d ≤ MAX_COUNT, else q <= MAX_COUNT (clamp).
  - ovf and unf <= 0. Load ignores en, M and sat.
- Count (en=1, load=0), M=0 (up):
  - q < MAX_COUNT: q <= q+1.
  - q == MAX_COUNT: q <= 0 if sat=0; q unchanged if sat=1.
  - ovf <= 1 in both boundary cases.
- Count (en=1, load=0), M=1 (down):
  - q > 0: q <= q-1.
  - q == 0: q <= MAX_COUNT if sat=0; q unchanged if sat=1.
  - unf <= 1 in both boundary cases.
- Hold (en=0, load=0): q unchanged; ovf, unf <= 0.
- ovf/unf are single-cycle pulses. If a saturated counter stays enabled at the boundary, the pulse re-asserts every enabled cycle.
- tc = en & ((!M & q==MAX_COUNT) | (M & q==0)). Zero-latency so the next stage's en can be driven from tc within the same cycle.
- Direction change is legal on any cycle and takes effect on that edge.
- Arithmetic is WIDTH bits. The wrap compare uses MAX_COUNT, not the natural 2**WIDTH rollover.
- Reset asserted mid-count: immediate clear. Reset release is synchronous to the design's reset synchroniser; the counter samples normally from the first edge after release.

Optional Feature:
- Macro: SYNC_UPDOWN_GRAY_OUT_EN.
- Defined:
  - Adds output port g [WIDTH-1:0], registered Gray-code encoding of the next q (g = q_next ^ (q_next>>1)), updated on the same edge as q. Gives glitch-free multi-bit crossing to other clock domains.
  - Reset value is 0.
  - Requires MAX_COUNT = 2**WIDTH-1 for single-bit-change wrap; a compile-time check errors otherwise.
- Undefined: port g is absent; no extra flops.

Decomposition:
- Shared package counter_pkg:
  - localparam encodings DIR_UP=1'b0, DIR_DOWN=1'b1, MODE_WRAP=1'b0, MODE_SAT=1'b1.
  - A function bin2gray(WIDTH-generic via max-width vector).
- One sub-module: counter_next_logic (combinational).
  - Inputs: q, en, M, sat, load, d.
  - Outputs: q_next, ovf_next, unf_next, tc.
  - Keeps the register shell in sync_updown_counter_n trivial.

Test Plan:
- Reset/up wrap: WIDTH=4, MAX_COUNT=15. Release reset, en=1, M=0, sat=0 for 17 cycles → q 0,1..15,0,1; ovf high exactly on the cycle after q=15; tc high while q=15.
- BCD down wrap: MAX_COUNT=9, load d=2, then M=1, en=1 → q 2,1,0,9,8; unf pulses once after 0→9; tc high only at q=0.
- Saturate: sat=1, M=0, load d=13 (MAX=15), en=1 for 5 cycles → q 14,15,15,15,15; ovf high on each of the last three edges.
- Load clamp/priority: MAX_COUNT=9, load=1 with d=12 and en=1, M=0 → q=9, ovf=0; next cycle en=1 → q=0, ovf=1.
- Async reset mid-count: q=7, drop reset between edges → q=0, qb=4'hF immediately without a clock edge.
- Cascade: two instances (MAX=9), upper en = lower tc; run 100 cycles up → combined {upper,lower} reads 00→99 and wraps to 00. With SYNC_UPDOWN_GRAY_OUT_EN, g changes exactly one bit per increment across a full 4-bit wrap.
